// File: rtl/subtratores_pkg.sv
// rtl/subtratores_pkg.sv - shared state encodings and default width for the serial subtractor
package subtratores_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CALCULA = 2'd1,
      FIM     = 2'd2
   } estado_t;

endpackage

// File: rtl/subtrator_serial_if.sv
// rtl/subtrator_serial_if.sv - requester-side handshake and operand/result bundle
interface subtrator_serial_if #(
   parameter int WIDTH = subtratores_pkg::WIDTH_DEFAULT
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ocupado;
   logic             pronto;
   logic [WIDTH-1:0] diferenca;
   logic             emprestimo;

   modport master (
      output start, a, b,
      input  ocupado, pronto, diferenca, emprestimo
   );

   modport slave (
      input  start, a, b,
      output ocupado, pronto, diferenca, emprestimo
   );

endinterface

// File: rtl/subtrator_completo.sv
// rtl/subtrator_completo.sv - 1-bit full subtractor built from two half subtractors
module meio_subtrator (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

module subtrator_completo (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1;
   logic b1;
   logic b2;

   meio_subtrator u_ms1 (.a(a),  .b(b),   .d(d1), .bout(b1));
   meio_subtrator u_ms2 (.a(d1), .b(bin), .d(d),  .bout(b2));

   assign bout = b1 | b2;

endmodule

// File: rtl/subtrator_serial.sv
// rtl/subtrator_serial.sv - bit-serial a-b controller, LSB first, one bit per cycle
module subtrator_serial
   import subtratores_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   subtrator_serial_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] ULTIMO = CW'(WIDTH - 1);

   estado_t          estado;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] diferenca_r;
   logic             emprestimo_r;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic             d;
   logic             bout;

   subtrator_completo u_celula (
      .a    (sa[0]),
      .b    (sb[0]),
      .bin  (borrow),
      .d    (d),
      .bout (bout)
   );

   // Result bits enter at the MSB so after WIDTH shifts the LSB lands at bit 0.
   assign res_next = {d, res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado       <= OCIOSO;
         sa           <= '0;
         sb           <= '0;
         res          <= '0;
         diferenca_r  <= '0;
         emprestimo_r <= 1'b0;
         borrow       <= 1'b0;
         cnt          <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (bus.start) begin
                  sa     <= bus.a;
                  sb     <= bus.b;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  estado <= CALCULA;
               end
            end
            CALCULA: begin
               res    <= res_next;
               sa     <= sa >> 1;
               sb     <= sb >> 1;
               borrow <= bout;
               if (cnt == ULTIMO) begin
                  diferenca_r  <= res_next;
                  emprestimo_r <= bout;
                  estado       <= FIM;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIM: begin
               estado <= OCIOSO;
            end
            default: begin
               estado <= OCIOSO;
            end
         endcase
      end
   end

   assign bus.ocupado    = (estado == CALCULA);
   assign bus.pronto     = (estado == FIM);
   assign bus.diferenca  = diferenca_r;
   assign bus.emprestimo = emprestimo_r;

endmodule
